// File: rtl/pixel_stream_writer_pkg.sv
// Shared types and pixel format for pixel_stream_writer.
// Define PIX_RGB444_EN to store and write 12-bit RGB444 instead of 24-bit RGB888.
package pixel_stream_writer_pkg;

`ifdef PIX_RGB444_EN
  localparam int unsigned DATA_W = 12;
`else
  localparam int unsigned DATA_W = 24;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // RGB444 keeps the top nibble of each channel (truncation, no rounding).
  function automatic logic [DATA_W-1:0] pack_pixel(input logic [23:0] c);
`ifdef PIX_RGB444_EN
    return {c[23:20], c[15:12], c[7:4]};
`else
    return c;
`endif
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with combinational head; DEPTH must be a power of 2.
// Push while full is accepted when a pop happens in the same cycle.
module pixel_fifo
  import pixel_stream_writer_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pixel_stream_writer.sv
// Buffers the shader pixel stream in a small FIFO and writes it to the framebuffer in raster order.
// Pixel width follows PIX_RGB444_EN (12-bit when defined, 24-bit otherwise).
module pixel_stream_writer
  import pixel_stream_writer_pkg::*;
#(
  parameter int unsigned H_RES      = 320,
  parameter int unsigned V_RES      = 240,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [23:0]       color,
  input  logic              color_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  input  logic              fb_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int unsigned       PIXELS    = H_RES * V_RES;
  localparam logic [ADDR_W:0]   PIXELS_C  = (ADDR_W+1)'(PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  if ((longint'(H_RES) * longint'(V_RES)) > (longint'(1) << ADDR_W)) begin : g_addr_check
    $error("pixel_stream_writer: ADDR_W too small for H_RES*V_RES");
  end

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("pixel_stream_writer: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   acc_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accepting;
  logic              xfer;
  logic              push;
  logic              drop_full;

  // A pixel arriving with frame_start is discarded along with the flushed FIFO.
  assign accepting = (state_q == ST_RUN) && !frame_start && color_valid && (acc_cnt < PIXELS_C);
  assign xfer      = fb_we && fb_ready;
  assign push      = accepting && (!fifo_full || xfer);
  assign drop_full = accepting && fifo_full && !xfer;

  pixel_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (push),
    .pop   (xfer),
    .din   (pack_pixel(color)),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN:  if (xfer && (fb_addr == LAST_ADDR)) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == ST_RUN);
    fb_we      = (state_q == ST_RUN) && !fifo_empty;
    fb_wdata   = fb_we ? fifo_head : '0;
    frame_done = (state_q == ST_DONE) && !frame_start;
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      acc_cnt  <= '0;
      fb_addr  <= '0;
      overflow <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (push)      acc_cnt  <= acc_cnt + 1'b1;
      if (xfer)      fb_addr  <= fb_addr + 1'b1;
      if (drop_full) overflow <= 1'b1;
    end
  end

endmodule
